// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : SPI mode-0 initiator for 16-bit register frames, MSB first,
//               with programmable SCLK divider and chip-select timing.
// Revision    : 1.0 - initial release
// ============================================================================

module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_data,
    output logic [15:0] rx_data,
    output logic        done,
    output logic        busy,
    output logic        sclk,
    output logic        copi,
    input  logic        cipo,
    output logic        ncs
);

    localparam int c_MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int c_MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int c_MAX_CNT = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CW      = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CW-1:0] c_DIV_LAST   = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_SETUP_LAST = c_CW'(CS_SETUP - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST  = c_CW'(CS_HOLD - 1);
    // The IDLE cycle in which the next accept can occur is the last high
    // cycle of the inter-frame gap, so GAP itself lasts CS_IDLE-1 cycles.
    localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'((CS_IDLE > 1) ? (CS_IDLE - 2) : 0);
    localparam bit              c_SKIP_GAP   = (CS_IDLE == 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_SETUP = 3'd1;
    localparam logic [2:0] c_S_SHIFT = 3'd2;
    localparam logic [2:0] c_S_HOLD  = 3'd3;
    localparam logic [2:0] c_S_GAP   = 3'd4;

    logic [2:0]      r_state, w_state_next;
    logic [c_CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]      r_bit, w_bit_next;
    logic [14:0]     r_tx, w_tx_next;
    logic [15:0]     r_rx, w_rx_next;
    logic [15:0]     w_rx_data_next;
    logic            w_sclk_next, w_copi_next, w_ncs_next;
    logic            w_ready_next, w_busy_next, w_done_next;

    logic w_accept, w_shift_tick, w_frame_end, w_gap_end;

    assign w_accept     = req_valid && req_ready && (r_state == c_S_IDLE);
    assign w_shift_tick = (r_state == c_S_SHIFT) && (r_cnt == c_DIV_LAST);
    assign w_frame_end  = (r_state == c_S_HOLD) && (r_cnt == c_HOLD_LAST);
    assign w_gap_end    = ((r_state == c_S_GAP) && (r_cnt == c_GAP_LAST)) ||
                          (w_frame_end && c_SKIP_GAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            rx_data   <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_tx      <= w_tx_next;
            r_rx      <= w_rx_next;
            rx_data   <= w_rx_data_next;
            sclk      <= w_sclk_next;
            copi      <= w_copi_next;
            ncs       <= w_ncs_next;
            req_ready <= w_ready_next;
            busy      <= w_busy_next;
            done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        case (r_state)
            c_S_IDLE: begin
                w_cnt_next = '0;
                if (w_accept) w_state_next = c_S_SETUP;
            end
            c_S_SETUP: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_state_next = c_S_SHIFT;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                end
            end
            c_S_SHIFT: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_next = '0;
                    // r_bit counts falling edges; the 16th one ends the shift.
                    if (sclk) begin
                        if (r_bit == 4'd15) w_state_next = c_S_HOLD;
                        else                w_bit_next   = r_bit + 4'd1;
                    end
                end
            end
            c_S_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = c_SKIP_GAP ? c_S_IDLE : c_S_GAP;
                end
            end
            c_S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_tx_next      = r_tx;
        w_rx_next      = r_rx;
        w_rx_data_next = rx_data;
        w_sclk_next    = sclk;
        w_copi_next    = copi;
        w_ncs_next     = ncs;
        w_ready_next   = req_ready;
        w_busy_next    = busy;
        w_done_next    = 1'b0;

        if (w_accept) begin
            w_tx_next    = {req_addr, req_data};
            w_copi_next  = req_rw;
            w_ncs_next   = 1'b0;
            w_ready_next = 1'b0;
            w_busy_next  = 1'b1;
        end

        if (w_shift_tick) begin
            w_sclk_next = ~sclk;
            if (!sclk) begin
                w_rx_next = {r_rx[14:0], cipo};
            end else if (r_bit != 4'd15) begin
                w_copi_next = r_tx[14];
                w_tx_next   = {r_tx[13:0], 1'b0};
            end
        end

        if (w_frame_end) begin
            w_ncs_next     = 1'b1;
            w_rx_data_next = r_rx;
            w_done_next    = 1'b1;
        end

        if (w_gap_end) begin
            w_ready_next = 1'b1;
            w_busy_next  = 1'b0;
            w_copi_next  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Directed self-checking bench for spi_controller (two timing
//               configurations, shared stimulus, per-cycle bus monitor).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_spi_controller;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_rw, cipo, sel;
    logic [6:0]  req_addr;
    logic [7:0]  req_data;

    logic        ready0, done0, busy0, sclk0, copi0, ncs0;
    logic        ready1, done1, busy1, sclk1, copi1, ncs1;
    logic [15:0] rx0, rx1;

    logic        m_ready, m_done, m_busy, m_sclk, m_copi, m_ncs;
    logic [15:0] m_rx;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready0),
        .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .rx_data(rx0), .done(done0), .busy(busy0), .sclk(sclk0),
        .copi(copi0), .cipo(cipo), .ncs(ncs0)
    );

    spi_controller #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready1),
        .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .rx_data(rx1), .done(done1), .busy(busy1), .sclk(sclk1),
        .copi(copi1), .cipo(cipo), .ncs(ncs1)
    );

    assign m_ready = sel ? ready1 : ready0;
    assign m_done  = sel ? done1  : done0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_sclk  = sel ? sclk1  : sclk0;
    assign m_copi  = sel ? copi1  : copi0;
    assign m_ncs   = sel ? ncs1   : ncs0;
    assign m_rx    = sel ? rx1    : rx0;

    int          n_chk = 0, n_fail = 0;
    int          rises, falls, ncs_low, dones, bad_edge, hi_run, last_gap;
    int          cyc = 0, first_rise, last_rise, pidx, n, k;
    logic [15:0] cap, rx_at_done, pat;
    logic        prev_sclk, prev_ncs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        rises = 0; falls = 0; ncs_low = 0; dones = 0; bad_edge = 0;
        cap = '0; rx_at_done = '0; first_rise = 0; last_rise = 0;
    endtask

    // One clock: sample outputs 1 time unit after the edge, update the
    // monitor, then let the peripheral model present its next CIPO bit.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m_sclk && !prev_sclk) begin
            rises++;
            cap = {cap[14:0], m_copi};
            if (rises == 1) first_rise = cyc;
            last_rise = cyc;
            if (m_ncs) bad_edge++;
        end
        if (!m_sclk && prev_sclk) begin
            falls++;
            if (m_ncs) bad_edge++;
        end
        if (!m_ncs) ncs_low++;
        if (!m_ncs && prev_ncs) begin
            last_gap = hi_run;
            hi_run   = 0;
        end
        if (m_ncs) hi_run++;
        if (m_done) begin
            dones++;
            rx_at_done = m_rx;
        end
        if (!m_ncs && prev_ncs) begin
            pidx = 15;
            cipo = pat[15];
        end else if (!m_sclk && prev_sclk && pidx > 0) begin
            pidx--;
            cipo = pat[pidx];
        end
        prev_sclk = m_sclk;
        prev_ncs  = m_ncs;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!m_ready && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk("ready_timeout", m_ready, 1);
    endtask

    // Counts cycles from the accepting cycle to the first cycle ready is high.
    task automatic run_frame(input logic [15:0] w, input bit keep,
                             input logic [15:0] w_after, output int cnt);
        int wn;
        {req_rw, req_addr, req_data} = w;
        req_valid = 1'b1;
        tick();
        chk("accept_busy", m_busy, 1);
        {req_rw, req_addr, req_data} = w_after;
        if (!keep) req_valid = 1'b0;
        wait_ready(wn);
        cnt = wn + 1;
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; req_valid = 1'b1;
        {req_rw, req_addr, req_data} = 16'h8123;
        cipo = 1'b0; pat = '0; pidx = 0;
        prev_sclk = 1'b0; prev_ncs = 1'b1; hi_run = 0; last_gap = 0;
        clr_mon();

        // Reset with a pending request: reset wins.
        tick(); tick();
        chk("reset_ctrl", {m_ncs, m_sclk, m_copi, m_ready, m_busy, m_done}, 6'b100100);
        chk("reset_rx", m_rx, 16'h0000);
        req_valid = 1'b0; rst = 1'b0;
        tick();
        chk("no_accept_in_reset", {m_busy, m_ncs}, 2'b01);

        // Basic frame, DIV=2
        pat = 16'hA55A; clr_mon();
        run_frame(16'h80F0, 1'b0, 16'h7FFF, n);
        chk("f1_copi_word", cap, 16'h80F0);
        chk("f1_rises", rises, 16);
        chk("f1_falls", falls, 16);
        chk("f1_ncs_low", ncs_low, 68);
        chk("f1_done_count", dones, 1);
        chk("f1_rx_at_done", rx_at_done, 16'hA55A);
        chk("f1_ready_latency", n, 72);
        chk("f1_sclk_span", last_rise - first_rise, 60);
        chk("f1_no_edge_ncs_high", bad_edge, 0);
        chk("f1_idle_copi_busy", {m_copi, m_busy}, 2'b00);
        cipo = 1'b1;
        repeat (10) tick();
        chk("f1_rx_held", m_rx, 16'hA55A);
        chk("f1_no_extra_done", dones, 1);

        // Back-to-back with req_valid held high
        pat = 16'h3C0F; clr_mon();
        run_frame(16'h8101, 1'b1, 16'h8204, n);
        chk("b2b_first_word", cap, 16'h8101);
        chk("b2b_first_rx", rx_at_done, 16'h3C0F);
        chk("b2b_first_latency", n, 72);
        clr_mon();
        tick();
        chk("b2b_second_accept", m_busy, 1);
        chk("b2b_ncs_gap", last_gap, 4);
        req_valid = 1'b0;
        {req_rw, req_addr, req_data} = 16'h0000;
        wait_ready(n);
        chk("b2b_second_word", cap, 16'h8204);
        chk("b2b_second_rises", rises, 16);
        chk("b2b_second_done", dones, 1);

        // Reset in the middle of a frame
        pat = 16'hF00F; clr_mon();
        {req_rw, req_addr, req_data} = 16'h8AAA;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (rises < 7 && k < 500) begin
            tick();
            k++;
        end
        chk("mid_rise7_reached", rises, 7);
        rst = 1'b1;
        tick();
        chk("mid_reset_ctrl", {m_ncs, m_sclk, m_ready, m_busy, m_done}, 5'b10100);
        chk("mid_reset_rx", m_rx, 16'h0000);
        rst = 1'b0;
        repeat (40) tick();
        chk("mid_no_done", dones, 0);
        chk("mid_no_late_edges", rises, 7);
        clr_mon();
        run_frame(16'h8055, 1'b0, 16'hFFFF, n);
        chk("post_reset_word", cap, 16'h8055);
        chk("post_reset_rises", rises, 16);
        chk("post_reset_rx", rx_at_done, 16'hF00F);
        chk("post_reset_latency", n, 72);

        // DIV=1 configuration
        sel = 1'b1; pat = 16'h0FF0; clr_mon();
        tick();
        run_frame(16'h80F0, 1'b0, 16'h1234, n);
        chk("d1_copi_word", cap, 16'h80F0);
        chk("d1_rises", rises, 16);
        chk("d1_falls", falls, 16);
        chk("d1_ncs_low", ncs_low, 36);
        chk("d1_sclk_span", last_rise - first_rise, 30);
        chk("d1_ready_latency", n, 40);
        chk("d1_done_count", dones, 1);
        chk("d1_rx_at_done", rx_at_done, 16'h0FF0);
        chk("d1_no_edge_ncs_high", bad_edge, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI mode-0 controller: the initiator end of the 16-bit register-write link into the chip's SPI peripheral, which feeds the PWM control registers.
- Accepts one command per valid/ready handshake and serialises it MSB-first on COPI.
- Generates SCLK and nCS with programmable timing.
- Captures 16 bits from CIPO during the same frame and reports them with a done pulse. Used by the on-chip/test-harness side to drive register writes.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (legal >= 1).
- CS_SETUP, 2, clk cycles nCS low before the first SCLK rising edge window starts (legal >= 1).
- CS_HOLD, 2, clk cycles after the last SCLK falling edge before nCS rises (legal >= 1).
- CS_IDLE, 4, minimum clk cycles nCS stays high between frames (legal >= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  controller can accept a command.
- req_rw  in  1  frame bit 15; 1 = write.
- req_addr  in  7  frame bits 14:8.
- req_data  in  8  frame bits 7:0.
- rx_data  out  16  CIPO word of the last completed frame.
- done  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high from accept until IDLE is re-entered.
- sclk  out  1  SPI clock, idles low.
- copi  out  1  serial data to the peripheral.
- cipo  in  1  serial data from the peripheral; already synchronous to the SPI domain, sampled directly.
- ncs  out  1  chip select, active-low.

Behaviour:
- All outputs are registered. The same clk edge that asserts rst (rst=1) drives: state IDLE, sclk=0, copi=0, ncs=1, req_ready=1, busy=0, done=0, rx_data=0, all counters=0.
- Accept happens on a clk edge with req_valid && req_ready. tx_shift latches {req_rw, req_addr, req_data}.
- On that same edge: state goes to SETUP, ncs=0, copi=req_rw, req_ready=0, busy=1.
- SETUP:
  - Hold sclk=0 for CS_SETUP cycles.
  - Then go to SHIFT with half-period counter=0 and bit counter=0.
- SHIFT:
  - sclk toggles every CLK_DIV cycles. Starts low for CLK_DIV cycles, then high, for 16 full periods (32*CLK_DIV cycles).
  - On the edge that drives sclk 0->1: rx_shift <= {rx_shift[14:0], cipo}.
  - On the edge that drives sclk 1->0, bits 1..15: copi advances to the next bit.
  - On the 16th falling edge: copi holds its last value, then go to HOLD.
- HOLD:
  - CS_HOLD cycles with sclk=0 and ncs=0.
  - Then ncs=1, rx_data <= rx_shift, done=1 for exactly one cycle, go to GAP.
- GAP:
  - CS_IDLE cycles with ncs=1.
  - Then go to IDLE with req_ready=1 and busy=0. copi returns to 0 in IDLE.
- ncs low duration is exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles.
- Accept to req_ready high again is that duration + CS_IDLE cycles.
- Boundary conditions:
  - req_valid while req_ready=0: ignored. req_* may change freely during a frame; only the value latched at accept is sent.
  - req_valid held high continuously: back-to-back frames separated by exactly CS_IDLE cycles of ncs high.
  - req_valid and rst in the same cycle: reset wins; nothing is accepted.
  - rst mid-frame: next edge forces the reset state, ncs=1, sclk=0. No done pulse; rx_data is cleared.
- Exactly 16 rising and 16 falling sclk edges per frame. No sclk edge while ncs=1.

Test Plan:
- CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_IDLE=4; send rw=1, addr=0x00, data=0xF0 -> copi bits sampled on sclk rises read 0x80F0; ncs low 68 cycles; done pulses once; req_ready returns 72 cycles after accept.
- cipo driven by a model shifting 0xA55A on falling edges during a frame -> rx_data=0xA55A at the done pulse; rx_data unchanged until the next done.
- req_valid held high with two successive commands (0x8101, then 0x8204) -> two frames, ncs high exactly 4 cycles between them; the second command is not sampled early.
- Change req_addr/req_data mid-frame -> transmitted word equals the value latched at accept.
- rst asserted at the 7th sclk rising edge -> next cycle ncs=1, sclk=0, busy=0, req_ready=1; no done; a new command afterwards transmits a full 16 bits.
- CLK_DIV=1 -> sclk period 2 clk cycles; 16 rises counted; frame integrity as in the first scenario.
